// File: rtl/conv_pkg.sv
// Shared convolution types and defaults, used by the window feeder and the PE.
package conv_pkg;

   localparam int unsigned KNL_SIZE_DEF     = 5;
   localparam int unsigned DATA_WIDTH_DEF   = 16;
   localparam int unsigned WEIGHT_WIDTH_DEF = 16;
   localparam int unsigned WGT_AW           = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } feeder_state_e;

   // Qualifiers travelling alongside each beat
   typedef struct packed {
      logic first;
      logic last;
      logic frame_last;
   } beat_tag_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Kernel/window position counters and picture/weight address arithmetic.
module window_addr_gen
   import conv_pkg::*;
#(
   parameter int unsigned KNL_SIZE   = KNL_SIZE_DEF,
   parameter int unsigned IMG_W      = 32,
   parameter int unsigned IMG_H      = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] pic_addr_c,
   output logic [WGT_AW-1:0]     wgt_addr_c,
   output beat_tag_t             tag_c
);

   localparam int unsigned NWX = IMG_W - KNL_SIZE + 1;
   localparam int unsigned NWY = IMG_H - KNL_SIZE + 1;
   localparam int unsigned KW  = cnt_width(KNL_SIZE);
   localparam int unsigned XW  = cnt_width(NWX);
   localparam int unsigned YW  = cnt_width(NWY);

   logic [KW-1:0] kx, ky;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic          kx_last, ky_last, wx_last, wy_last;

   assign kx_last = (kx == KW'(KNL_SIZE - 1));
   assign ky_last = (ky == KW'(KNL_SIZE - 1));
   assign wx_last = (win_x == XW'(NWX - 1));
   assign wy_last = (win_y == YW'(NWY - 1));

   // Odometer: kx fastest, then ky, then win_x, then win_y
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kx    <= '0;
         ky    <= '0;
         win_x <= '0;
         win_y <= '0;
      end else if (clear) begin
         kx    <= '0;
         ky    <= '0;
         win_x <= '0;
         win_y <= '0;
      end else if (step) begin
         if (!kx_last) begin
            kx <= kx + KW'(1);
         end else begin
            kx <= '0;
            if (!ky_last) begin
               ky <= ky + KW'(1);
            end else begin
               ky <= '0;
               if (!wx_last) begin
                  win_x <= win_x + XW'(1);
               end else begin
                  win_x <= '0;
                  win_y <= wy_last ? '0 : win_y + YW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      pic_addr_c = (ADDR_WIDTH'(win_y) + ADDR_WIDTH'(ky)) * ADDR_WIDTH'(IMG_W)
                 + ADDR_WIDTH'(win_x) + ADDR_WIDTH'(kx);
      wgt_addr_c = WGT_AW'(ky) * WGT_AW'(KNL_SIZE) + WGT_AW'(kx);
      tag_c.first      = (kx == '0) && (ky == '0);
      tag_c.last       = kx_last && ky_last;
      tag_c.frame_last = kx_last && ky_last && wx_last && wy_last;
   end

endmodule

// File: rtl/conv_window_feeder.sv
// Streams KNL_SIZE x KNL_SIZE pixel/weight windows over an image to a PE.
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int unsigned KNL_SIZE     = KNL_SIZE_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int unsigned IMG_W        = 32,
   parameter int unsigned IMG_H        = 32,
   parameter int unsigned ADDR_WIDTH   = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    out_ready,
   output logic                    pic_rd_en,
   output logic [ADDR_WIDTH-1:0]   pic_addr,
   input  logic [DATA_WIDTH-1:0]   pic_rdata,
   output logic                    wgt_rd_en,
   output logic [WGT_AW-1:0]       wgt_addr,
   input  logic [WEIGHT_WIDTH-1:0] wgt_rdata,
   output logic [DATA_WIDTH-1:0]   picDat,
   output logic [WEIGHT_WIDTH-1:0] weightDat,
   output logic                    dat_valid,
   output logic                    win_first,
   output logic                    win_last,
   output logic                    frame_last,
   output logic                    busy,
   output logic                    done
);

   feeder_state_e         state, next_state;
   logic                  issue_c, clear_c;
   logic [ADDR_WIDTH-1:0] gen_pic_addr_c;
   logic [WGT_AW-1:0]     gen_wgt_addr_c;
   beat_tag_t             tag_c, tag_q;
   logic                  valid_q, busy_q, done_q;

   window_addr_gen #(
      .KNL_SIZE   (KNL_SIZE),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear_c),
      .step       (issue_c),
      .pic_addr_c (gen_pic_addr_c),
      .wgt_addr_c (gen_wgt_addr_c),
      .tag_c      (tag_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // DRAIN lasts exactly the cycle in which the final read's data returns
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_RUN;
         ST_RUN:   if (issue_c && tag_c.frame_last) next_state = ST_DRAIN;
         ST_DRAIN: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      issue_c = 1'b0;
      clear_c = 1'b0;
      case (state)
         ST_IDLE: clear_c = start;
         ST_RUN:  issue_c = out_ready;
         default: ;
      endcase
   end

   // Beat qualifiers follow the read by one cycle, matching memory latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= issue_c;
         tag_q   <= issue_c ? tag_c : '0;
         busy_q  <= (next_state != ST_IDLE);
         done_q  <= (state == ST_DRAIN);
      end
   end

   assign pic_rd_en  = issue_c;
   assign wgt_rd_en  = issue_c;
   assign pic_addr   = issue_c ? gen_pic_addr_c : '0;
   assign wgt_addr   = issue_c ? gen_wgt_addr_c : '0;
   assign picDat     = valid_q ? pic_rdata : '0;
   assign weightDat  = valid_q ? wgt_rdata : '0;
   assign dat_valid  = valid_q;
   assign win_first  = tag_q.first;
   assign win_last   = tag_q.last;
   assign frame_last = tag_q.frame_last;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder on a 6x6 image with a 5x5 kernel.
module tb_conv_window_feeder;

   localparam int IW  = 6;
   localparam int IH  = 6;
   localparam int KN  = 5;
   localparam int NWX = IW - KN + 1;
   localparam int NWY = IH - KN + 1;
   localparam int NBEATS = NWX * NWY * KN * KN;

   logic        clk = 1'b0;
   logic        rst_n, start, out_ready;
   logic        pic_rd_en, wgt_rd_en;
   logic [9:0]  pic_addr;
   logic [4:0]  wgt_addr;
   logic [15:0] pic_rdata, wgt_rdata, picDat, weightDat;
   logic        dat_valid, win_first, win_last, frame_last, busy, done;

   conv_window_feeder #(
      .KNL_SIZE(KN), .DATA_WIDTH(16), .WEIGHT_WIDTH(16),
      .IMG_W(IW), .IMG_H(IH), .ADDR_WIDTH(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
      .pic_rd_en(pic_rd_en), .pic_addr(pic_addr), .pic_rdata(pic_rdata),
      .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
      .picDat(picDat), .weightDat(weightDat), .dat_valid(dat_valid),
      .win_first(win_first), .win_last(win_last), .frame_last(frame_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [15:0] pic_mem [0:1023];
   logic [15:0] wgt_mem [0:31];

   always @(posedge clk) begin
      if (pic_rd_en) pic_rdata <= pic_mem[pic_addr];
      if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr];
   end

   typedef struct { logic [9:0] addr; logic [4:0] k; } exp_iss_t;
   typedef struct { logic [15:0] pic; logic [15:0] wgt; logic first; logic last; logic flast; } exp_beat_t;
   typedef struct { int ready_mode; int ones; int extra_start; int exp_done; } vec_t;

   exp_iss_t  iss_q[$];
   exp_beat_t beat_q[$];
   exp_iss_t  mi;
   exp_beat_t mb;

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   int iss_cnt = 0;
   int acc = 0;
   logic mon_en = 1'b0;
   logic acc_en = 1'b0;
   logic [9:0] issued_addr [0:255];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_mem(input int ones);
      for (int i = 0; i < 1024; i++) pic_mem[i] = (ones != 0) ? 16'd1 : 16'(i * 7 + 3);
      for (int i = 0; i < 32; i++)   wgt_mem[i] = (ones != 0) ? 16'd2 : 16'(i + 100);
   endtask

   // Reference order: win_y, win_x outer; ky, kx inner
   task automatic push_frame();
      exp_iss_t  ei;
      exp_beat_t eb;
      for (int wy = 0; wy < NWY; wy++)
         for (int wx = 0; wx < NWX; wx++)
            for (int ky = 0; ky < KN; ky++)
               for (int kx = 0; kx < KN; kx++) begin
                  ei.addr  = 10'((wy + ky) * IW + wx + kx);
                  ei.k     = 5'(ky * KN + kx);
                  eb.pic   = pic_mem[ei.addr];
                  eb.wgt   = wgt_mem[ei.k];
                  eb.first = (kx == 0) && (ky == 0);
                  eb.last  = (kx == KN - 1) && (ky == KN - 1);
                  eb.flast = eb.last && (wx == NWX - 1) && (wy == NWY - 1);
                  iss_q.push_back(ei);
                  beat_q.push_back(eb);
               end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (pic_rd_en || wgt_rd_en) begin
            checks++;
            if (iss_q.size() == 0) begin
               errors++;
               $display("FAIL extra_issue: got addr %0d expected no read", pic_addr);
            end else begin
               mi = iss_q.pop_front();
               if (pic_addr !== mi.addr || wgt_addr !== mi.k || pic_rd_en !== 1'b1 || wgt_rd_en !== 1'b1) begin
                  errors++;
                  $display("FAIL issue: got pic %0d wgt %0d en %b%b expected pic %0d wgt %0d en 11",
                           pic_addr, wgt_addr, pic_rd_en, wgt_rd_en, mi.addr, mi.k);
               end
            end
            if (iss_cnt < 256) issued_addr[iss_cnt] = pic_addr;
            iss_cnt++;
         end
         checks++;
         if (dat_valid) begin
            beat_cnt++;
            if (win_first) acc = 0;
            acc += int'(picDat) * int'(weightDat);
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got pic %0d expected no beat", picDat);
            end else begin
               mb = beat_q.pop_front();
               if (picDat !== mb.pic || weightDat !== mb.wgt || win_first !== mb.first ||
                   win_last !== mb.last || frame_last !== mb.flast) begin
                  errors++;
                  $display("FAIL beat: got pic %0d wgt %0d f/l/fl %b%b%b expected pic %0d wgt %0d f/l/fl %b%b%b",
                           picDat, weightDat, win_first, win_last, frame_last,
                           mb.pic, mb.wgt, mb.first, mb.last, mb.flast);
               end
            end
            if (acc_en && win_last) begin
               checks++;
               if (acc != 50) begin
                  errors++;
                  $display("FAIL window_acc: got %0d expected 50", acc);
               end
            end
         end else if ({picDat, weightDat, win_first, win_last, frame_last} !== '0) begin
            errors++;
            $display("FAIL idle_zero: got pic %0d wgt %0d quals %b%b%b expected all 0",
                     picDat, weightDat, win_first, win_last, frame_last);
         end
      end
   end

   function automatic longint all_outs();
      return longint'({pic_rd_en, pic_addr, wgt_rd_en, wgt_addr, picDat, weightDat,
                       dat_valid, win_first, win_last, frame_last, busy, done});
   endfunction

   task automatic run_frame(input vec_t v);
      int done_cyc, done_cnt, busy_cnt, b0;
      load_mem(v.ones);
      acc_en   = (v.ones != 0);
      push_frame();
      b0       = beat_cnt;
      iss_cnt  = 0;
      done_cyc = -1;
      done_cnt = 0;
      busy_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         out_ready = (v.ready_mode == 0) ? 1'b1 : 1'(c % 2);
         start     = (c == v.extra_start);
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk("done_cycle", done_cyc, v.exp_done);
      chk("done_count", done_cnt, 1);
      chk("busy_cycles", busy_cnt, v.exp_done - 1);
      chk("beat_count", beat_cnt - b0, NBEATS);
      chk("issues_left", iss_q.size(), 0);
      chk("beats_left", beat_q.size(), 0);
      chk("win1_first_addr", issued_addr[25], 1);
      chk("win1_last_addr", issued_addr[49], 29);
      acc_en = 1'b0;
   endtask

   vec_t vecs [4];

   initial begin
      int b0;
      logic hit;
      vecs[0] = '{ready_mode: 0, ones: 0, extra_start: 0,  exp_done: 102};
      vecs[1] = '{ready_mode: 1, ones: 0, extra_start: 0,  exp_done: 201};
      vecs[2] = '{ready_mode: 0, ones: 0, extra_start: 50, exp_done: 102};
      vecs[3] = '{ready_mode: 0, ones: 1, extra_start: 0,  exp_done: 102};

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      load_mem(0);
      #1;
      chk("reset_outputs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i]);
         repeat (3) @(posedge clk);
         #1;
      end

      // Reset in the middle of a frame, at the 37th delivered beat
      load_mem(0);
      push_frame();
      b0 = beat_cnt;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk); #1;
         if (beat_cnt - b0 >= 37) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reached_beat37", longint'(hit), 1);
      chk("beat37_valid", longint'(dat_valid), 1);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      iss_q.delete();
      beat_q.delete();
      #1;
      chk("midreset_outputs", all_outs(), 0);
      @(posedge clk); #1;
      chk("midreset_next_edge", all_outs(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      b0 = beat_cnt;
      iss_cnt = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("no_beats_after_reset", beat_cnt - b0, 0);
      chk("no_issue_after_reset", iss_cnt, 0);
      run_frame(vecs[0]);
      chk("restart_addr0", issued_addr[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter KNL_SIZE, default 5, kernel edge length (window = KNL_SIZE*KNL_SIZE beats).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, pixel width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 16, weight width.
REQ-004 SHALL have parameters IMG_W and IMG_H, default 32 each, image size in pixels, both >= KNL_SIZE.
REQ-005 SHALL have parameter ADDR_WIDTH, default 10, picture memory address width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle frame start request.
REQ-009 SHALL have port out_ready, input, 1, consumer permits a new read issue.
REQ-010 SHALL have ports pic_rd_en (output, 1), pic_addr (output, ADDR_WIDTH), pic_rdata (input, DATA_WIDTH): picture memory, 1-cycle read latency.
REQ-011 SHALL have ports wgt_rd_en (output, 1), wgt_addr (output, 5), wgt_rdata (input, WEIGHT_WIDTH): weight memory, 1-cycle read latency.
REQ-012 SHALL have ports picDat (output, DATA_WIDTH) and weightDat (output, WEIGHT_WIDTH), the beat delivered to the PE.
REQ-013 SHALL have ports dat_valid, win_first, win_last, frame_last (output, 1 each), beat qualifiers.
REQ-014 SHALL have ports busy and done (output, 1 each), frame status.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after last read issue; DRAIN -> IDLE after last beat delivered.
REQ-016 SHALL ignore start when not in IDLE.
REQ-017 SHALL issue one read (pic_rd_en=wgt_rd_en=1) per cycle in RUN when out_ready=1; none when out_ready=0.
REQ-018 SHALL order beats within a window row-major: k = ky*KNL_SIZE+kx, k from 0 to KNL_SIZE*KNL_SIZE-1.
REQ-019 SHALL drive pic_addr = (win_y+ky)*IMG_W + (win_x+kx) and wgt_addr = k on the issue cycle.
REQ-020 SHALL step windows stride 1, win_x 0..IMG_W-KNL_SIZE inner, win_y 0..IMG_H-KNL_SIZE outer, no padding.
REQ-021 SHALL assert dat_valid exactly one cycle after each issue, with picDat=pic_rdata and weightDat=wgt_rdata that cycle.
REQ-022 SHALL deliver an in-flight beat even if out_ready has dropped (no backpressure on issued reads).
REQ-023 SHALL assert win_first on k=0 beats, win_last on k=KNL_SIZE*KNL_SIZE-1 beats, frame_last on final beat of final window; all only with dat_valid.
REQ-024 SHALL hold busy=1 from the cycle after accepted start through the frame_last beat.
REQ-025 SHALL pulse done for one cycle, the cycle after the frame_last beat.
REQ-026 SHALL keep all counters modulo their limits with no wrap beyond the final window; counters reset to 0 on entry to RUN.
REQ-027 SHALL drive picDat/weightDat to 0 when dat_valid=0.

Reset
REQ-028 SHALL, on rst_n=0 at any time (including mid-frame), return to IDLE, clear all counters, and drive every output to 0 asynchronously.
REQ-029 SHALL discard any in-flight read at reset; no beat is delivered after reset release until a new start.

Structure
REQ-030 SHALL take KNL_SIZE, widths and FSM state encoding from shared package conv_pkg, reused by the PE.
REQ-031 SHALL contain one sub-module, window_addr_gen (kx/ky/win_x/win_y counters and address arithmetic); FSM and output pipeline in top.

Verification
REQ-032 SHALL test IMG_W=IMG_H=6, out_ready=1, start pulse -> 4 windows, 100 consecutive beats, done at cycle 102 after start.
REQ-033 SHALL test address order: window 1 (win_x=1) first beat pic_addr=1, last beat pic_addr=4*6+5=29, wgt_addr 0..24.
REQ-034 SHALL test out_ready toggling 1/0 each cycle -> 200-cycle frame, beat sequence identical to REQ-032.
REQ-035 SHALL test start during busy -> ignored, frame count unchanged, single done.
REQ-036 SHALL test rst_n low at beat 37 -> all outputs 0 next edge, no dat_valid after release, new start restarts at pic_addr=0.
REQ-037 SHALL test end-to-end with PE, memory pixel=1, weight=2 -> each window accumulates 50.
